// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, reads instruction memory over req/ack,
// and hands {instruction, pc} to decode over valid/ready, honouring redirects.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_count,
  output logic        misalign_err
);

  // Handshakes: imem side completes on imem_req & imem_ack (addr held until then);
  // decode side transfers on inst_valid & inst_ready (payload held until then).
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_FULL = 2'd1,
    S_KILL = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [31:0] ipc_q, ipc_d;
  logic [31:0] count_q, count_d;
  logic        valid_q, valid_d;
  logic        misalign_q, misalign_d;

  logic [31:0] tgt;
  logic        ack;
  logic        xfer;

  assign tgt  = {redirect_target[31:2], 2'b00};
  assign ack  = imem_req && imem_ack;
  assign xfer = valid_q && inst_ready;

  assign imem_req     = ((state_q == S_REQ) || (state_q == S_KILL)) && !rst;
  assign imem_addr    = addr_q;
  assign inst_valid   = valid_q;
  assign inst_data    = data_q;
  assign inst_pc      = ipc_q;
  assign inst_count   = count_q;
  assign misalign_err = misalign_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    data_d     = data_q;
    ipc_d      = ipc_q;
    valid_d    = valid_q;
    count_d    = count_q + (xfer ? 32'd1 : 32'd0);
    misalign_d = misalign_q | (redirect_valid && (redirect_target[1:0] != 2'b00));

    case (state_q)
      S_REQ: begin
        if (ack && redirect_valid) begin
          pc_d   = tgt;
          addr_d = tgt;
        end else if (ack) begin
          data_d  = imem_rdata;
          ipc_d   = addr_q;
          valid_d = 1'b1;
          pc_d    = addr_q + 32'd4;
          state_d = S_FULL;
        end else if (redirect_valid) begin
          // The in-flight read must still complete at its original address.
          pc_d    = tgt;
          state_d = S_KILL;
        end
      end
      S_KILL: begin
        if (ack && redirect_valid) begin
          pc_d    = tgt;
          addr_d  = tgt;
          state_d = S_REQ;
        end else if (ack) begin
          addr_d  = pc_q;
          state_d = S_REQ;
        end else if (redirect_valid) begin
          pc_d = tgt;
        end
      end
      S_FULL: begin
        if (redirect_valid) begin
          valid_d = 1'b0;
          pc_d    = tgt;
          addr_d  = tgt;
          state_d = S_REQ;
        end else if (inst_ready) begin
          valid_d = 1'b0;
          addr_d  = pc_q;
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_REQ;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      addr_q     <= RESET_PC;
      data_q     <= 32'd0;
      ipc_q      <= 32'd0;
      valid_q    <= 1'b0;
      count_q    <= 32'd0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      ipc_q      <= ipc_d;
      valid_q    <= valid_d;
      count_q    <= count_d;
      misalign_q <= misalign_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a scripted memory model drives acks, a negedge
// monitor scores fetched instructions and memory addresses against expected queues.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [31:0] inst_count;
  logic        misalign_err;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst_data       (inst_data),
    .inst_pc         (inst_pc),
    .inst_count      (inst_count),
    .misalign_err    (misalign_err)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_q[$];       // {pc, data} of each instruction decode should see
  logic [31:0] exp_addr_q[$];  // address of each request memory will acknowledge
  int mem_delay = 0;
  int wait_cnt = 0;
  bit mem_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0010) return 32'hDEAD_BEEF;
    return a ^ 32'hC0DE_0000;
  endfunction

  // One clock: inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    imem_ack = 1'b0;
    if (imem_req && mem_en) begin
      if (wait_cnt >= mem_delay) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        wait_cnt   = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  endtask

  task automatic wait_count(input logic [31:0] target, input int budget);
    int n = 0;
    while (inst_count != target && n < budget) begin
      step();
      n++;
    end
    n_checks++;
    if (inst_count != target) begin
      n_errors++;
      $display("FAIL wait_count: got %0d expected %0d within %0d cycles", inst_count, target, budget);
    end
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!inst_valid && n < budget) begin
      step();
      n++;
    end
    n_checks++;
    if (!inst_valid) begin
      n_errors++;
      $display("FAIL wait_valid: got inst_valid=0 expected 1 within %0d cycles", budget);
    end
  endtask

  task automatic redirect(input logic [31:0] target);
    redirect_valid  = 1'b1;
    redirect_target = target;
    step();
    redirect_valid  = 1'b0;
  endtask

  // Monitor: scoreboard pops plus hold-stability checks, sampled on the falling edge.
  logic        prev_hold = 1'b0;
  logic        prev_wait = 1'b0;
  logic [31:0] prev_data = 32'd0;
  logic [31:0] prev_pc   = 32'd0;
  logic [31:0] prev_addr = 32'd0;
  logic [63:0] mon_e;
  logic [31:0] mon_a;

  always @(negedge clk) begin
    if (inst_valid && prev_hold) begin
      check("hold_data", inst_data, prev_data);
      check("hold_pc", inst_pc, prev_pc);
    end
    if (imem_req && prev_wait) check("addr_stable", imem_addr, prev_addr);
    if (inst_valid && inst_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_inst: got pc %h data %h expected no transfer", inst_pc, inst_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("inst_pc", inst_pc, mon_e[63:32]);
        check("inst_data", inst_data, mon_e[31:0]);
      end
    end
    if (imem_req && imem_ack) begin
      if (exp_addr_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_req: got addr %h expected no acknowledged request", imem_addr);
      end else begin
        mon_a = exp_addr_q.pop_front();
        check("imem_addr", imem_addr, mon_a);
      end
    end
    prev_hold = inst_valid && !inst_ready;
    prev_wait = imem_req && !imem_ack;
    prev_data = inst_data;
    prev_pc   = inst_pc;
    prev_addr = imem_addr;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    imem_ack = 1'b0;
    imem_rdata = 32'd0;
    redirect_valid = 1'b0;
    redirect_target = 32'd0;
    inst_ready = 1'b0;
    step();
    step();

    // Reset state
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_data", inst_data, 32'd0);
    check("rst_pc", inst_pc, 32'd0);
    check("rst_count", inst_count, 32'd0);
    check("rst_misalign", 32'(misalign_err), 32'd0);

    // Sequential fetch 0x0, 0x4, 0x8 (then 0xC used by the backpressure case)
    exp_addr_q.push_back(32'h0);
    exp_addr_q.push_back(32'h4);
    exp_addr_q.push_back(32'h8);
    exp_addr_q.push_back(32'hC);
    exp_q.push_back({32'h0, 32'hC0DE_0000});
    exp_q.push_back({32'h4, 32'hC0DE_0004});
    exp_q.push_back({32'h8, 32'hC0DE_0008});
    exp_q.push_back({32'hC, 32'hC0DE_000C});
    mem_delay = 1;
    mem_en = 1'b1;
    inst_ready = 1'b1;
    rst = 1'b0;
    #1;
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", imem_addr, 32'h0);
    wait_count(32'd3, 40);
    check("seq_count", inst_count, 32'd3);

    // Backpressure: 0xC held in the buffer for five cycles
    inst_ready = 1'b0;
    wait_valid(20);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_req", 32'(imem_req), 32'd0);
      check("bp_valid", 32'(inst_valid), 32'd1);
      check("bp_pc", inst_pc, 32'hC);
      check("bp_data", inst_data, 32'hC0DE_000C);
      check("bp_count", inst_count, 32'd3);
    end
    exp_addr_q.push_back(32'h10);
    mem_en = 1'b0;
    inst_ready = 1'b1;
    step();
    check("bp_xfer_count", inst_count, 32'd4);
    check("bp_next_req", 32'(imem_req), 32'd1);
    check("bp_next_addr", imem_addr, 32'h10);

    // Redirects while 0x10 is outstanding; the later target wins
    redirect(32'h180);
    check("kill_addr_hold", imem_addr, 32'h10);
    redirect(32'h100);
    check("kill_req", 32'(imem_req), 32'd1);
    check("kill_addr", imem_addr, 32'h10);
    step();
    step();
    mem_delay = 0;
    mem_en = 1'b1;
    step();
    mem_en = 1'b0;
    step();
    check("kill_no_valid", 32'(inst_valid), 32'd0);
    check("kill_next_req", 32'(imem_req), 32'd1);
    check("kill_next_addr", imem_addr, 32'h100);
    step();
    check("kill_still_no_valid", 32'(inst_valid), 32'd0);

    // Redirect coincident with ack in REQ: data dropped, target requested next cycle
    exp_addr_q.push_back(32'h100);
    mem_en = 1'b1;
    step();
    mem_en = 1'b0;
    redirect(32'h300);
    check("coinc_valid", 32'(inst_valid), 32'd0);
    check("coinc_req", 32'(imem_req), 32'd1);
    check("coinc_addr", imem_addr, 32'h300);
    check("coinc_count", inst_count, 32'd4);

    // Redirect in FULL with inst_ready=1: transfer counted, then flush
    exp_addr_q.push_back(32'h300);
    exp_q.push_back({32'h300, 32'hC0DE_0300});
    inst_ready = 1'b0;
    mem_en = 1'b1;
    step();
    mem_en = 1'b0;
    step();
    check("full_valid", 32'(inst_valid), 32'd1);
    check("full_pc", inst_pc, 32'h300);
    inst_ready = 1'b1;
    redirect(32'h400);
    check("full_redir_count", inst_count, 32'd5);
    check("full_redir_valid", 32'(inst_valid), 32'd0);
    check("full_redir_req", 32'(imem_req), 32'd1);
    check("full_redir_addr", imem_addr, 32'h400);

    // Misaligned redirect to 0x203 while 0x400 is outstanding
    redirect(32'h203);
    check("mis_err", 32'(misalign_err), 32'd1);
    check("mis_kill_addr", imem_addr, 32'h400);
    exp_addr_q.push_back(32'h400);
    exp_addr_q.push_back(32'h200);
    exp_q.push_back({32'h200, 32'hC0DE_0200});
    mem_delay = 1;
    mem_en = 1'b1;
    wait_count(32'd6, 30);
    mem_en = 1'b0;
    check("mis_err_sticky", 32'(misalign_err), 32'd1);
    check("mis_next_addr", imem_addr, 32'h204);

    // Reset with 0x204 outstanding
    step();
    rst = 1'b1;
    #1;
    check("midrst_req", 32'(imem_req), 32'd0);
    step();
    check("midrst_valid", 32'(inst_valid), 32'd0);
    check("midrst_count", inst_count, 32'd0);
    check("midrst_misalign", 32'(misalign_err), 32'd0);
    rst = 1'b0;
    #1;
    check("midrst_req_after", 32'(imem_req), 32'd1);
    check("midrst_addr_after", imem_addr, 32'h0);
    exp_addr_q.push_back(32'h0);
    exp_q.push_back({32'h0, 32'hC0DE_0000});
    mem_en = 1'b1;
    wait_count(32'd1, 20);
    mem_en = 1'b0;
    step();
    step();

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("exp_addr_q_drained", 32'(exp_addr_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
